wb_unit: RTL and testbench

Writeback stage of the 5-stage pipeline: holds the MEM/WB pipeline register, selects ALU result or load data, and drives the register-file write port that the decode stage reads from. It also keeps a per-register in-flight scoreboard (issue from decode, retire here, cancel on squash), exports the MEM/WB destination to hazard detection, and counts retired instructions.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_if.sv | 43 ++++
 rtl/wb_scoreboard.sv | 66 ++++++
 rtl/wb_unit.sv | 65 ++++++
 tb/tb_wb_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the MEM/WB slot layout for the writeback stage.
package wb_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned SB_CNT_W   = 2;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  to_reg;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data;
  } wb_slot_t;

endpackage

// File: rtl/wb_if.sv
// Writeback stage bus: EX/MEM fields, pipeline control, scoreboard events and
// register-file write port. slave = wb_unit side, master = pipeline side.
interface wb_if;
  import wb_pkg::*;

  logic                  stall;
  logic                  flush;
  logic                  mem_valid;
  logic                  mem_reg_write;
  logic                  mem_to_reg;
  logic [REG_ADDR_W-1:0] mem_reg_rd;
  logic [DATA_W-1:0]     mem_alu_result;
  logic [DATA_W-1:0]     mem_read_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_reg_rd;
  logic                  cancel_valid;
  logic [REG_ADDR_W-1:0] cancel_reg_rd;

  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] reg_rd_wb;
  logic [DATA_W-1:0]     reg_rd_data;
  logic [REG_ADDR_W-1:0] MEM_WB_reg_rd;
  logic [NUM_REGS-1:0]   reg_busy;
  logic [15:0]           retire_count;
  logic                  sb_error;

  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_to_reg, mem_reg_rd,
           mem_alu_result, mem_read_data, issue_valid, issue_reg_rd,
           cancel_valid, cancel_reg_rd,
    output RegWrite, reg_rd_wb, reg_rd_data, MEM_WB_reg_rd, reg_busy,
           retire_count, sb_error
  );

  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_to_reg, mem_reg_rd,
           mem_alu_result, mem_read_data, issue_valid, issue_reg_rd,
           cancel_valid, cancel_reg_rd,
    input  RegWrite, reg_rd_wb, reg_rd_data, MEM_WB_reg_rd, reg_busy,
           retire_count, sb_error
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register in-flight writer counters: one increment and two decrement
// event ports per cycle, saturating at [0, max] with a sticky error flag.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_valid,
  input  logic [REG_ADDR_W-1:0] inc_rd,
  input  logic                  dec_a_valid,
  input  logic [REG_ADDR_W-1:0] dec_a_rd,
  input  logic                  dec_b_valid,
  input  logic [REG_ADDR_W-1:0] dec_b_rd,
  output logic [NUM_REGS-1:0]   reg_busy,
  output logic                  sb_error
);

  localparam int CNT_MAX = (1 << SB_CNT_W) - 1;

  logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
  logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];
  logic                err_d;

  always_comb begin
    int n;
    n     = 0;
    err_d = sb_error;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      // R0 is hardwired zero, so events naming it are ignored.
      if (i != 0) begin
        n = int'(cnt_q[i])
          + ((inc_valid   && inc_rd   == REG_ADDR_W'(i)) ? 1 : 0)
          - ((dec_a_valid && dec_a_rd == REG_ADDR_W'(i)) ? 1 : 0)
          - ((dec_b_valid && dec_b_rd == REG_ADDR_W'(i)) ? 1 : 0);
        if (n < 0) begin
          cnt_d[i] = '0;
          err_d    = 1'b1;
        end else if (n > CNT_MAX) begin
          cnt_d[i] = '1;
          err_d    = 1'b1;
        end else begin
          cnt_d[i] = SB_CNT_W'(n);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '{default: '0};
      sb_error <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_error <= err_d;
    end
  end

  always_comb begin
    reg_busy = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      reg_busy[i] = (cnt_q[i] != '0);
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: MEM/WB register, load/ALU write mux, register-file write
// port, retire counter and the in-flight destination scoreboard.
module wb_unit
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  wb_if.slave  bus
);

  wb_slot_t    slot_q;
  logic        retire;
  logic        reg_write_en;
  logic [15:0] retire_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (bus.flush) begin
      slot_q <= '0;
    end else if (!bus.stall) begin
      slot_q.valid      <= bus.mem_valid;
      slot_q.reg_write  <= bus.mem_reg_write;
      slot_q.to_reg     <= bus.mem_to_reg;
      slot_q.rd         <= bus.mem_reg_rd;
      slot_q.alu_result <= bus.mem_alu_result;
      slot_q.read_data  <= bus.mem_read_data;
    end
  end

  // A stalled slot retires only in the first unstalled cycle, so the write is
  // gated by the live stall/flush rather than by the registered slot alone.
  always_comb begin
    retire       = slot_q.valid & ~bus.stall & ~bus.flush;
    reg_write_en = retire & slot_q.reg_write & (slot_q.rd != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_count_q <= '0;
    end else if (retire) begin
      retire_count_q <= retire_count_q + 16'd1;
    end
  end

  assign bus.RegWrite      = reg_write_en;
  assign bus.reg_rd_wb     = slot_q.rd;
  assign bus.reg_rd_data   = slot_q.to_reg ? slot_q.read_data : slot_q.alu_result;
  assign bus.MEM_WB_reg_rd = (slot_q.valid & slot_q.reg_write) ? slot_q.rd : '0;
  assign bus.retire_count  = retire_count_q;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_valid   (bus.issue_valid),
    .inc_rd      (bus.issue_reg_rd),
    .dec_a_valid (reg_write_en),
    .dec_a_rd    (slot_q.rd),
    .dec_b_valid (bus.cancel_valid),
    .dec_b_rd    (bus.cancel_reg_rd),
    .reg_busy    (bus.reg_busy),
    .sb_error    (bus.sb_error)
  );

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_wb_unit;

  logic clk;
  logic rst_n;
  wb_if bus ();

  wb_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Behavioural model: one pending instruction, writer counts per register.
  bit          started = 0;
  bit          m_valid, m_we, m_ld;
  int          m_rd;
  logic [15:0] m_alu, m_ldd;
  int          m_cnt [16];
  int          m_retired;
  bit          m_err;

  always @(posedge clk) begin : model
    bit ret, wr;
    int n;
    if (!rst_n) begin
      started = 1;
      m_valid = 0; m_we = 0; m_ld = 0; m_rd = 0; m_alu = 0; m_ldd = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_retired = 0;
      m_err = 0;
    end else begin
      ret = m_valid && !bus.stall && !bus.flush;
      wr  = ret && m_we && (m_rd != 0);
      if (ret) m_retired = (m_retired + 1) % 65536;
      for (int i = 1; i < 16; i++) begin
        n = m_cnt[i];
        if (bus.issue_valid && int'(bus.issue_reg_rd) == i) n = n + 1;
        if (wr && m_rd == i) n = n - 1;
        if (bus.cancel_valid && int'(bus.cancel_reg_rd) == i) n = n - 1;
        if (n < 0) begin n = 0; m_err = 1; end
        if (n > 3) begin n = 3; m_err = 1; end
        m_cnt[i] = n;
      end
      if (bus.flush) m_valid = 0;
      else if (!bus.stall) begin
        m_valid = bus.mem_valid;
        m_we    = bus.mem_reg_write;
        m_ld    = bus.mem_to_reg;
        m_rd    = int'(bus.mem_reg_rd);
        m_alu   = bus.mem_alu_result;
        m_ldd   = bus.mem_read_data;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit          e_we;
    logic [15:0] e_busy;
    if (started) begin
      e_we = m_valid && !bus.stall && !bus.flush && m_we && (m_rd != 0);
      e_busy = '0;
      for (int i = 1; i < 16; i++) e_busy[i] = (m_cnt[i] > 0);
      chk("m_RegWrite", 32'(bus.RegWrite), 32'(e_we));
      chk("m_MEM_WB_reg_rd", 32'(bus.MEM_WB_reg_rd), (m_valid && m_we) ? 32'(m_rd) : 32'd0);
      if (m_valid) begin
        chk("m_reg_rd_wb", 32'(bus.reg_rd_wb), 32'(m_rd));
        chk("m_reg_rd_data", 32'(bus.reg_rd_data), 32'(m_ld ? m_ldd : m_alu));
      end
      chk("m_reg_busy", 32'(bus.reg_busy), 32'(e_busy));
      chk("m_retire_count", 32'(bus.retire_count), 32'(m_retired));
      chk("m_sb_error", 32'(bus.sb_error), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0;
    bus.mem_valid = 0; bus.mem_reg_write = 0; bus.mem_to_reg = 0; bus.mem_reg_rd = '0;
    bus.mem_alu_result = '0; bus.mem_read_data = '0;
    bus.issue_valid = 0; bus.issue_reg_rd = '0;
    bus.cancel_valid = 0; bus.cancel_reg_rd = '0;
  endtask

  task automatic set_mem(input logic [3:0] rd, input logic ld, input logic [15:0] alu,
                         input logic [15:0] rdata, input logic iss);
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_to_reg = ld; bus.mem_reg_rd = rd;
    bus.mem_alu_result = alu; bus.mem_read_data = rdata;
    bus.issue_valid = iss; bus.issue_reg_rd = rd;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_RegWrite"}, 32'(bus.RegWrite), 32'd0);
    chk({tag, "_reg_rd_wb"}, 32'(bus.reg_rd_wb), 32'd0);
    chk({tag, "_reg_rd_data"}, 32'(bus.reg_rd_data), 32'd0);
    chk({tag, "_MEM_WB_reg_rd"}, 32'(bus.MEM_WB_reg_rd), 32'd0);
    chk({tag, "_reg_busy"}, 32'(bus.reg_busy), 32'd0);
    chk({tag, "_retire_count"}, 32'(bus.retire_count), 32'd0);
    chk({tag, "_sb_error"}, 32'(bus.sb_error), 32'd0);
  endtask

  initial begin
    rst_n = 0;
    idle();
    cyc(); cyc();
    @(negedge clk); chk_zero("reset");
    rst_n = 1;

    // ALU write to R3 (issued the same cycle it enters EX/MEM).
    set_mem(4'd3, 0, 16'h1234, 16'h0000, 1); cyc(); idle();
    @(negedge clk);
    chk("alu_RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("alu_rd_wb", 32'(bus.reg_rd_wb), 32'd3);
    chk("alu_data", 32'(bus.reg_rd_data), 32'h1234);
    chk("alu_MEM_WB", 32'(bus.MEM_WB_reg_rd), 32'd3);
    chk("alu_busy", 32'(bus.reg_busy), 32'h0008);
    cyc(); @(negedge clk);
    chk("alu_retire_count", 32'(bus.retire_count), 32'd1);
    chk("alu_busy_clear", 32'(bus.reg_busy), 32'd0);

    // Load write to R5.
    set_mem(4'd5, 1, 16'h0040, 16'hBEEF, 1); cyc(); idle();
    @(negedge clk);
    chk("load_RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("load_data", 32'(bus.reg_rd_data), 32'hBEEF);
    cyc();

    // R0 destination.
    set_mem(4'd0, 0, 16'h5555, 16'h0000, 0); cyc(); idle();
    @(negedge clk);
    chk("r0_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("r0_MEM_WB", 32'(bus.MEM_WB_reg_rd), 32'd0);
    cyc(); @(negedge clk);
    chk("r0_retire_count", 32'(bus.retire_count), 32'd3);

    // Stall three cycles on a slot targeting R7.
    set_mem(4'd7, 0, 16'h7777, 16'h0000, 1); cyc(); idle();
    bus.stall = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_RegWrite", 32'(bus.RegWrite), 32'd0);
      chk("stall_rd_wb", 32'(bus.reg_rd_wb), 32'd7);
      cyc();
    end
    bus.stall = 0;
    @(negedge clk);
    chk("stall_release_RegWrite", 32'(bus.RegWrite), 32'd1);
    cyc(); @(negedge clk);
    chk("stall_after_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("stall_retire_count", 32'(bus.retire_count), 32'd4);

    // Scoreboard: two issues to R4, then retire one at a time.
    bus.issue_valid = 1; bus.issue_reg_rd = 4'd4; cyc(); cyc(); idle();
    set_mem(4'd4, 0, 16'h0004, 16'h0000, 0); cyc(); idle(); cyc();
    @(negedge clk);
    chk("sb_busy_after_one", 32'(bus.reg_busy), 32'h0010);
    set_mem(4'd4, 0, 16'h0004, 16'h0000, 0); cyc(); idle(); cyc();
    @(negedge clk);
    chk("sb_busy_after_two", 32'(bus.reg_busy), 32'h0000);
    // Same-cycle issue and retire on R4 with one writer already in flight.
    bus.issue_valid = 1; bus.issue_reg_rd = 4'd4; cyc(); idle();
    set_mem(4'd4, 0, 16'h0044, 16'h0000, 0); cyc(); idle();
    bus.issue_valid = 1; bus.issue_reg_rd = 4'd4; cyc(); idle();
    @(negedge clk);
    chk("sb_busy_same_cycle", 32'(bus.reg_busy), 32'h0010);
    set_mem(4'd4, 0, 16'h0045, 16'h0000, 0); cyc(); idle(); cyc();
    @(negedge clk);
    chk("sb_busy_drained", 32'(bus.reg_busy), 32'h0000);
    chk("sb_no_error_yet", 32'(bus.sb_error), 32'd0);
    chk("sb_retire_count", 32'(bus.retire_count), 32'd8);
    bus.cancel_valid = 1; bus.cancel_reg_rd = 4'd9; cyc(); idle();
    @(negedge clk);
    chk("sb_underflow_error", 32'(bus.sb_error), 32'd1);
    cyc(); cyc(); @(negedge clk);
    chk("sb_error_sticky", 32'(bus.sb_error), 32'd1);

    // Flush with stall on a valid slot.
    set_mem(4'd6, 0, 16'h6666, 16'h0000, 1); cyc(); idle();
    bus.stall = 1; bus.flush = 1;
    @(negedge clk);
    chk("flush_RegWrite", 32'(bus.RegWrite), 32'd0);
    cyc(); idle();
    @(negedge clk);
    chk("flush_bubble_RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("flush_bubble_MEM_WB", 32'(bus.MEM_WB_reg_rd), 32'd0);
    chk("flush_retire_count", 32'(bus.retire_count), 32'd8);

    // Reset mid-flight.
    rst_n = 0; cyc(); rst_n = 1;
    @(negedge clk); chk_zero("midreset");

    // Randomized traffic; the compare process checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      rst_n              = ($urandom_range(0, 299) != 0);
      bus.stall          = ($urandom_range(0, 5) == 0);
      bus.flush          = ($urandom_range(0, 11) == 0);
      bus.mem_valid      = ($urandom_range(0, 3) != 0);
      bus.mem_reg_write  = ($urandom_range(0, 3) != 0);
      bus.mem_to_reg     = 1'($urandom);
      bus.mem_reg_rd     = 4'($urandom);
      bus.mem_alu_result = 16'($urandom);
      bus.mem_read_data  = 16'($urandom);
      bus.issue_valid    = ($urandom_range(0, 2) == 0);
      bus.issue_reg_rd   = 4'($urandom);
      bus.cancel_valid   = ($urandom_range(0, 9) == 0);
      bus.cancel_reg_rd  = 4'($urandom);
      cyc();
    end
    idle();
    rst_n = 1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
